// File: rtl/dac_frame_sequencer_if.sv
// rtl/dac_frame_sequencer_if.sv - sample-set input and SPI-side frame word bundle for dac_frame_sequencer
//
// Signals:
//   ch0_in..ch3_in  12-bit channel samples A..D
//   sample_stb      capture strobe for the four samples
//   ena_in          per-frame load strobe from the SPI shift stage
//   data_out        24-bit command word presented to the SPI stage
//   frame_ch        channel index of the word on data_out
//   busy            a sample set is in flight
//   done            pulse after the ch3 word of a set has been loaded
//   overrun         pulse when an unsent pending set is overwritten
// The sequencer takes the slave view; the driver of samples and strobes takes the master view.
interface dac_frame_sequencer_if;
    logic [11:0] ch0_in;
    logic [11:0] ch1_in;
    logic [11:0] ch2_in;
    logic [11:0] ch3_in;
    logic        sample_stb;
    logic        ena_in;
    logic [23:0] data_out;
    logic [1:0]  frame_ch;
    logic        busy;
    logic        done;
    logic        overrun;

    modport master (
        output ch0_in, ch1_in, ch2_in, ch3_in, sample_stb, ena_in,
        input  data_out, frame_ch, busy, done, overrun
    );

    modport slave (
        input  ch0_in, ch1_in, ch2_in, ch3_in, sample_stb, ena_in,
        output data_out, frame_ch, busy, done, overrun
    );
endinterface

// File: rtl/dac_frame_sequencer.sv
// rtl/dac_frame_sequencer.sv - formats four-channel sample sets into 24-bit DAC command frames
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; all state cleared immediately
//   bus    dac_frame_sequencer_if.slave (samples, strobes, frame word and status)
//
// A captured set waits in the pending buffer until the SPI stage asks for a
// frame; it is then copied to the active buffer so later captures cannot
// disturb the set being sent. With no set in flight a NOP word is shown.
module dac_frame_sequencer #(
    parameter bit         SYNC_UPDATE = 1'b1,
    parameter logic [3:0] CMD_WU      = 4'b0011,
    parameter logic [3:0] CMD_WR      = 4'b0000,
    parameter logic [3:0] CMD_WUALL   = 4'b0010,
    parameter logic [3:0] CMD_NOP     = 4'b1111
) (
    input logic                  clk,
    input logic                  reset,
    dac_frame_sequencer_if.slave bus
);

    localparam logic [23:0] NOP_WORD = {CMD_NOP, 4'hF, 12'h000, 4'h0};

    typedef enum logic {IDLE, SEND} state_t;

    // With synchronous update only the last channel of a set latches the
    // outputs, so all four DAC outputs move together.
    function automatic logic [23:0] word(input logic [1:0] ch, input logic [11:0] d);
        logic [3:0] cmd;
        if (SYNC_UPDATE) begin
            cmd = (ch == 2'd3) ? CMD_WUALL : CMD_WR;
        end else begin
            cmd = CMD_WU;
        end
        return {cmd, 2'b00, ch, d, 4'h0};
    endfunction

    state_t           state, state_n;
    logic [3:0][11:0] pending, pending_n;
    logic [3:0][11:0] active, active_n;
    logic             pflag, pflag_n;
    logic [23:0]      data_q, data_n;
    logic [1:0]       fch_q, fch_n;
    logic             done_q, done_n;
    logic             ovr_q, ovr_n;
    logic             consume;
    logic [1:0]       fch_inc;

    assign fch_inc = fch_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            active  <= '0;
            pflag   <= 1'b0;
            data_q  <= NOP_WORD;
            fch_q   <= 2'd0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            active  <= active_n;
            pflag   <= pflag_n;
            data_q  <= data_n;
            fch_q   <= fch_n;
            done_q  <= done_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        active_n  = active;
        pflag_n   = pflag;
        data_n    = data_q;
        fch_n     = fch_q;
        done_n    = 1'b0;
        ovr_n     = 1'b0;
        consume   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ena_in && pflag) begin
                    consume  = 1'b1;
                    active_n = pending;
                    data_n   = word(2'd0, pending[0]);
                    fch_n    = 2'd0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (bus.ena_in) begin
                    if (fch_q != 2'd3) begin
                        fch_n  = fch_inc;
                        data_n = word(fch_inc, active[fch_inc]);
                    end else begin
                        done_n = 1'b1;
                        fch_n  = 2'd0;
                        if (pflag) begin
                            // Back-to-back set: no NOP frame between sets.
                            consume  = 1'b1;
                            active_n = pending;
                            data_n   = word(2'd0, pending[0]);
                        end else begin
                            data_n  = NOP_WORD;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                data_n  = NOP_WORD;
                fch_n   = 2'd0;
            end
        endcase

        if (consume) begin
            pflag_n = 1'b0;
        end

        // A capture on the same edge that drains pending is not an overrun:
        // the old set has just moved to active.
        if (bus.sample_stb) begin
            pending_n = {bus.ch3_in, bus.ch2_in, bus.ch1_in, bus.ch0_in};
            pflag_n   = 1'b1;
            ovr_n     = pflag && !consume;
        end
    end

    assign bus.data_out = data_q;
    assign bus.frame_ch = fch_q;
    assign bus.busy     = (state == SEND);
    assign bus.done     = done_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb/tb_dac_frame_sequencer.sv - self-checking bench for dac_frame_sequencer
module tb_dac_frame_sequencer;

    localparam logic [23:0] NOP = 24'hFF0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dac_frame_sequencer_if if1 ();
    dac_frame_sequencer_if if0 ();

    dac_frame_sequencer #(.SYNC_UPDATE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    dac_frame_sequencer #(.SYNC_UPDATE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          stb;
        bit          ena;
        logic [47:0] smp;   // {ch0, ch1, ch2, ch3}
        logic [23:0] w1;    // expected word, synchronous update
        logic [23:0] w0;    // expected word, per-channel update
        logic [1:0]  fch;
        bit          busy;
        bit          done;
        bit          ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit stb, input bit ena, input logic [47:0] smp);
        if1.sample_stb = stb;  if0.sample_stb = stb;
        if1.ena_in     = ena;  if0.ena_in     = ena;
        if1.ch0_in = smp[47:36]; if0.ch0_in = smp[47:36];
        if1.ch1_in = smp[35:24]; if0.ch1_in = smp[35:24];
        if1.ch2_in = smp[23:12]; if0.ch2_in = smp[23:12];
        if1.ch3_in = smp[11:0];  if0.ch3_in = smp[11:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [23:0] e1, input logic [23:0] e0,
                             input logic [1:0] fch, input bit busy, input bit done, input bit ovr);
        chk({tag, ".data_out_sync"}, 32'(if1.data_out), 32'(e1));
        chk({tag, ".data_out_wu"},   32'(if0.data_out), 32'(e0));
        chk({tag, ".frame_ch_sync"}, 32'(if1.frame_ch), 32'(fch));
        chk({tag, ".frame_ch_wu"},   32'(if0.frame_ch), 32'(fch));
        chk({tag, ".busy_sync"},     32'(if1.busy),     32'(busy));
        chk({tag, ".busy_wu"},       32'(if0.busy),     32'(busy));
        chk({tag, ".done_sync"},     32'(if1.done),     32'(done));
        chk({tag, ".done_wu"},       32'(if0.done),     32'(done));
        chk({tag, ".overrun_sync"},  32'(if1.overrun),  32'(ovr));
        chk({tag, ".overrun_wu"},    32'(if0.overrun),  32'(ovr));
    endtask

    // Reference model: the set in flight is a FIFO of {channel, sample} still
    // to be shown; "shown" is what the SPI stage would load on the next strobe.
    logic [13:0] mq[$];
    logic [13:0] shown;
    bit          shown_valid;
    logic [11:0] mpend[4];
    bit          mflag;
    bit          m_done, m_ovr;

    function automatic logic [23:0] mword(input bit sync, input logic [1:0] ch, input logic [11:0] d);
        logic [3:0] cmd;
        if (sync) cmd = (ch == 2'd3) ? 4'b0010 : 4'b0000;
        else      cmd = 4'b0011;
        return {cmd, 2'b00, ch, d, 4'h0};
    endfunction

    task automatic model_reset;
        mq.delete();
        shown_valid = 1'b0;
        shown = '0;
        mflag = 1'b0;
        for (int i = 0; i < 4; i++) mpend[i] = '0;
    endtask

    task automatic model_step(input bit stb, input bit ena, input logic [47:0] smp);
        m_done = 1'b0;
        m_ovr  = 1'b0;
        if (ena) begin
            if (shown_valid && shown[13:12] == 2'd3) m_done = 1'b1;
            if (mq.size() > 0) begin
                shown = mq.pop_front();
            end else if (mflag) begin
                for (int i = 0; i < 4; i++) mq.push_back({2'(i), mpend[i]});
                shown = mq.pop_front();
                shown_valid = 1'b1;
                mflag = 1'b0;
            end else begin
                shown_valid = 1'b0;
            end
        end
        if (stb) begin
            m_ovr = mflag;
            mpend[0] = smp[47:36];
            mpend[1] = smp[35:24];
            mpend[2] = smp[23:12];
            mpend[3] = smp[11:0];
            mflag = 1'b1;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 48'h0);
        tick;
        tick;
        check_all("reset_state", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Strobes with nothing pending keep the NOP frame and never signal done.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 48'h0);
            tick;
            check_all("idle_ena", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 48'h0);
            for (int j = 0; j < 49; j++) begin
                tick;
                check_all("idle_gap", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);
            end
        end

        vecs.push_back('{1'b1, 1'b0, 48'h123456789ABC, NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h001230, 24'h301230, 2'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 48'h0, 24'h001230, 24'h301230, 2'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h014560, 24'h314560, 2'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h027890, 24'h327890, 2'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h23ABC0, 24'h33ABC0, 2'd3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 48'h0, 24'h23ABC0, 24'h33ABC0, 2'd3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, NOP, NOP, 2'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 48'h0, NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 48'h111111111111, NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 48'h222222222222, NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 48'h0, NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h002220, 24'h302220, 2'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h012220, 24'h312220, 2'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h022220, 24'h322220, 2'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 48'h333333333333, 24'h232220, 24'h332220, 2'd3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 48'h444444444444, 24'h003330, 24'h303330, 2'd0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h013330, 24'h313330, 2'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h023330, 24'h323330, 2'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h233330, 24'h333330, 2'd3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h004440, 24'h304440, 2'd0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 48'h0, 24'h014440, 24'h314440, 2'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 48'h555555555555, 24'h024440, 24'h324440, 2'd2, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stb, vecs[i].ena, vecs[i].smp);
            tick;
            check_all($sformatf("vec%0d", i), vecs[i].w1, vecs[i].w0, vecs[i].fch,
                      vecs[i].busy, vecs[i].done, vecs[i].ovr);
        end

        // Asynchronous reset with frame_ch=2 and a set pending.
        drive(1'b0, 1'b0, 48'h0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        reset = 1'b0;
        drive(1'b0, 1'b1, 48'h0);
        tick;
        check_all("post_reset_ena", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 48'h0);
        tick;
        check_all("post_reset_ena2", NOP, NOP, 2'd0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        drive(1'b0, 1'b0, 48'h0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit          stb, ena;
            logic [47:0] smp;
            stb = ($urandom_range(0, 7) == 0);
            ena = ($urandom_range(0, 2) == 0);
            smp = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            drive(stb, ena, smp);
            model_step(stb, ena, smp);
            tick;
            check_all("rand",
                      shown_valid ? mword(1'b1, shown[13:12], shown[11:0]) : NOP,
                      shown_valid ? mword(1'b0, shown[13:12], shown[11:0]) : NOP,
                      shown_valid ? shown[13:12] : 2'd0,
                      shown_valid, m_done, m_ovr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
